// File: rtl/lsu_dm_master_pkg.sv
// Shared definitions for the load/store initiator: access size codes,
// fault cause codes, FSM state encoding and the alignment check.
package lsu_dm_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2
    } lsu_state_e;

    // The reserved size code is reported as a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = a_lo[0];
            SZ_WORD: r = (a_lo != 2'b00);
            SZ_RSVD: r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_dm_master_load_fmt.sv
// Load result formatter (combinational).
// Ports:
//   size_i     access size code
//   unsigned_i 1 = zero-extend byte/half results
//   lo_i       low byte captured in the first halfword access
//   dm_dout_i  DM read data of the final access
//   rdata_o    32-bit load result
module lsu_dm_master_load_fmt
    import lsu_dm_master_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [7:0]  lo_i,
    input  logic [31:0] dm_dout_i,
    output logic [31:0] rdata_o
);

    logic [7:0] b;
    assign b = dm_dout_i[7:0];

    always_comb begin
        rdata_o = dm_dout_i;
        case (size_i)
            SZ_BYTE: rdata_o = unsigned_i ? {24'b0, b} : {{24{b[7]}}, b};
            // Second access of a halfword returns the high byte.
            SZ_HALF: rdata_o = unsigned_i ? {16'b0, b, lo_i} : {{16{b[7]}}, b, lo_i};
            default: rdata_o = dm_dout_i;
        endcase
    end

endmodule

// File: rtl/lsu_dm_master.sv
// Load/store initiator between the CPU MEM stage and the byte/word data memory.
// Accepts one request per handshake in IDLE, checks range and alignment,
// drives the DM port for one (byte/word) or two (halfword) cycles and returns
// an extended load result or a store completion pulse.
// Ports:
//   clk, clr_n                 clock, async active-low reset
//   req_*                      request handshake and payload
//   rsp_valid, rsp_rdata       completion pulse and held load result
//   fault, fault_cause         rejection pulse and held cause
//   dm_addr/dm_din/dm_wr/dm_byte/dm_dout   data memory port
module lsu_dm_master
    import lsu_dm_master_pkg::*;
#(
    parameter int DM_AW = 12
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_wr,
    output logic        dm_byte,
    input  logic [31:0] dm_dout
);

    lsu_state_e  state_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [7:0]  whi_q;
    logic [7:0]  lo_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        fault_q;
    logic [1:0]  fault_cause_q;
    logic [31:0] dm_addr_q;
    logic [31:0] dm_din_q;
    logic        dm_wr_q;
    logic        dm_byte_q;
    logic [31:0] fmt_rdata;
    logic        out_of_range;

    assign out_of_range = |req_addr[31:DM_AW];

    lsu_dm_master_load_fmt u_fmt (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lo_i       (lo_q),
        .dm_dout_i  (dm_dout),
        .rdata_o    (fmt_rdata)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= ST_IDLE;
            store_q       <= 1'b0;
            size_q        <= SZ_BYTE;
            uns_q         <= 1'b0;
            whi_q         <= 8'h00;
            lo_q          <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            dm_addr_q     <= 32'h0;
            dm_din_q      <= 32'h0;
            dm_wr_q       <= 1'b0;
            dm_byte_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    dm_wr_q   <= 1'b0;
                    dm_byte_q <= 1'b0;
                    if (req_valid) begin
                        if (out_of_range) begin
                            fault_q       <= 1'b1;
                            fault_cause_q <= CAUSE_RANGE;
                        end else if (is_misaligned(req_size, req_addr[1:0])) begin
                            fault_q       <= 1'b1;
                            fault_cause_q <= CAUSE_MISALIGN;
                        end else begin
                            store_q   <= req_store;
                            size_q    <= req_size;
                            uns_q     <= req_unsigned;
                            whi_q     <= req_wdata[15:8];
                            // DM port is set up here so it is registered during ACC1.
                            dm_addr_q <= req_addr;
                            dm_din_q  <= req_wdata;
                            dm_wr_q   <= req_store;
                            dm_byte_q <= (req_size != SZ_WORD);
                            state_q   <= ST_ACC1;
                        end
                    end
                end
                ST_ACC1: begin
                    if (size_q == SZ_HALF) begin
                        lo_q      <= dm_dout[7:0];
                        dm_addr_q <= dm_addr_q + 32'd1;
                        dm_din_q  <= {24'b0, whi_q};
                        dm_wr_q   <= store_q;
                        dm_byte_q <= 1'b1;
                        state_q   <= ST_ACC2;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        if (!store_q) rsp_rdata_q <= fmt_rdata;
                        dm_wr_q   <= 1'b0;
                        dm_byte_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ACC2: begin
                    rsp_valid_q <= 1'b1;
                    if (!store_q) rsp_rdata_q <= fmt_rdata;
                    dm_wr_q   <= 1'b0;
                    dm_byte_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    dm_wr_q   <= 1'b0;
                    dm_byte_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign dm_addr     = dm_addr_q;
    assign dm_din      = dm_din_q;
    assign dm_wr       = dm_wr_q;
    assign dm_byte     = dm_byte_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
module tb_lsu_dm_master;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  fault_cause;
    logic [31:0] dm_addr, dm_din, dm_dout;
    logic        dm_wr, dm_byte;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_dm_master #(.DM_AW(12)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .fault        (fault),
        .fault_cause  (fault_cause),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_wr        (dm_wr),
        .dm_byte      (dm_byte),
        .dm_dout      (dm_dout)
    );

    // Data memory model: async read, posedge write, byte read sign-extends.
    logic [7:0]  mem [0:4095];
    logic [11:0] a0;
    assign a0 = dm_addr[11:0];

    always @(posedge clk) begin
        if (dm_wr) begin
            mem[a0] <= dm_din[7:0];
            if (!dm_byte) begin
                mem[a0 + 12'd1] <= dm_din[15:8];
                mem[a0 + 12'd2] <= dm_din[23:16];
                mem[a0 + 12'd3] <= dm_din[31:24];
            end
        end
    end

    always_comb begin
        dm_dout = {mem[a0 + 12'd3], mem[a0 + 12'd2], mem[a0 + 12'd1], mem[a0]};
        if (dm_byte) dm_dout = {{24{mem[a0][7]}}, mem[a0]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Snapshot of the DM port in the first two cycles after accept.
    logic        s_wr1, s_byte1, s_wr2, s_byte2;
    logic [31:0] s_addr1, s_din1, s_addr2, s_din2;

    task automatic set_req(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
        req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    endtask

    // Issue one request (caller is #1 after a posedge, DUT idle). lat = cycles from
    // accept to rsp_valid/fault, -1 on timeout.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic flt);
        bit done;
        int i;
        set_req(st, sz, un, a, wd);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; flt = 1'b0; done = 1'b0; i = 1;
        while (!done && i <= 6) begin
            if (i == 1) begin s_wr1 = dm_wr; s_byte1 = dm_byte; s_addr1 = dm_addr; s_din1 = dm_din; end
            if (i == 2) begin s_wr2 = dm_wr; s_byte2 = dm_byte; s_addr2 = dm_addr; s_din2 = dm_din; end
            if (fault) begin flt = 1'b1; lat = i; done = 1'b1; end
            else if (rsp_valid) begin lat = i; done = 1'b1; end
            else begin @(posedge clk); #1; i++; end
        end
    endtask

    int   lat;
    logic flt;
    int   acc_cyc [3];
    int   rsp_cyc [3];
    logic [31:0] rd0;
    int   k, nr;
    bit   accepting;

    initial begin
        clr_n = 1'b0; req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_cause", 32'(fault_cause), 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        chk("rst_dm_wr", 32'(dm_wr), 32'h0);
        chk("rst_dm_byte", 32'(dm_byte), 32'h0);
        clr_n = 1'b1;
        @(posedge clk); #1;

        // 1: word store/load
        run_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, flt);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wr", 32'(s_wr1), 32'h1);
        chk("sw_byte", 32'(s_byte1), 32'h0);
        chk("sw_addr", s_addr1, 32'h40);
        run_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, flt);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", rsp_rdata, 32'hDEADBEEF);

        // 2: halfword store split into two byte writes, signed/unsigned loads
        run_op(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000A5F0, lat, flt);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wr1", 32'(s_wr1), 32'h1);
        chk("sh_byte1", 32'(s_byte1), 32'h1);
        chk("sh_addr1", s_addr1, 32'h42);
        chk("sh_din1", 32'(s_din1[7:0]), 32'hF0);
        chk("sh_wr2", 32'(s_wr2), 32'h1);
        chk("sh_byte2", 32'(s_byte2), 32'h1);
        chk("sh_addr2", s_addr2, 32'h43);
        chk("sh_din2", s_din2, 32'hA5);
        chk("sh_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        run_op(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, lat, flt);
        chk("lh_lat", 32'(lat), 32'd3);
        chk("lh_data", rsp_rdata, 32'hFFFFA5F0);
        run_op(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, flt);
        chk("lhu_data", rsp_rdata, 32'h0000A5F0);
        run_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, flt);
        chk("lw_after_sh", rsp_rdata, 32'hA5F0BEEF);

        // 3: byte store into a word, sign/zero loads
        run_op(1'b1, 2'b10, 1'b0, 32'h44, 32'h11223344, lat, flt);
        chk("sw44_rdata_hold", rsp_rdata, 32'hA5F0BEEF);
        run_op(1'b1, 2'b00, 1'b0, 32'h45, 32'h00000081, lat, flt);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_byte", 32'(s_byte1), 32'h1);
        run_op(1'b0, 2'b00, 1'b0, 32'h45, 32'h0, lat, flt);
        chk("lb_data", rsp_rdata, 32'hFFFFFF81);
        run_op(1'b0, 2'b00, 1'b1, 32'h45, 32'h0, lat, flt);
        chk("lbu_data", rsp_rdata, 32'h00000081);
        run_op(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, lat, flt);
        chk("lw44_data", rsp_rdata, 32'h11228144);

        // 4: faults
        run_op(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, flt);
        chk("lw_mis_fault", 32'(flt), 32'h1);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_cause", 32'(fault_cause), 32'h1);
        chk("lw_mis_wr", 32'(s_wr1), 32'h0);
        chk("lw_mis_ready", 32'(req_ready), 32'h1);
        run_op(1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF, lat, flt);
        chk("sh_mis_cause", 32'(fault_cause), 32'h1);
        chk("sh_mis_wr", 32'(s_wr1), 32'h0);
        run_op(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, lat, flt);
        chk("sw_range_fault", 32'(flt), 32'h1);
        chk("sw_range_cause", 32'(fault_cause), 32'h2);
        chk("sw_range_wr", 32'(s_wr1), 32'h0);
        chk("sw_range_ready", 32'(req_ready), 32'h1);
        run_op(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, lat, flt);
        chk("rsvd_cause", 32'(fault_cause), 32'h1);
        chk("fault_rdata_hold", rsp_rdata, 32'h11228144);
        run_op(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, lat, flt);
        chk("lb_range_cause", 32'(fault_cause), 32'h2);

        // 5: req_valid held high across LB, SH, LW
        for (int j = 0; j < 3; j++) begin acc_cyc[j] = -1; rsp_cyc[j] = -1; end
        k = 0; nr = 0; rd0 = 32'h0;
        set_req(1'b0, 2'b00, 1'b0, 32'h45, 32'h0);
        req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid && nr < 3) begin
                rsp_cyc[nr] = c;
                if (nr == 0) rd0 = rsp_rdata;
                nr++;
            end
            accepting = (req_ready && k < 3);
            if (accepting) acc_cyc[k] = c;
            @(posedge clk); #1;
            if (accepting) begin
                k++;
                if (k == 1) set_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h00007766);
                else if (k == 2) set_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
        chk("b2b_acc1", 32'(acc_cyc[1]), 32'd2);
        chk("b2b_acc2", 32'(acc_cyc[2]), 32'd5);
        chk("b2b_rsp0", 32'(rsp_cyc[0]), 32'd2);
        chk("b2b_rsp1", 32'(rsp_cyc[1]), 32'd5);
        chk("b2b_rsp2", 32'(rsp_cyc[2]), 32'd7);
        chk("b2b_lb_data", rd0, 32'hFFFFFF81);
        chk("b2b_lw_data", rsp_rdata, 32'hA5F0BEEF);
        chk("b2b_mem20", 32'(mem[12'h20]), 32'h66);
        chk("b2b_mem21", 32'(mem[12'h21]), 32'h77);

        // 6: reset in the middle of a halfword store
        run_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, lat, flt);
        set_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_acc1_wr", 32'(dm_wr), 32'h1);
        @(posedge clk); #1;
        chk("mid_acc2_addr", dm_addr, 32'h11);
        clr_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(dm_wr), 32'h0);
        chk("mid_rst_byte", 32'(dm_byte), 32'h0);
        chk("mid_rst_addr", dm_addr, 32'h0);
        chk("mid_rst_din", dm_din, 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_mem10", 32'(mem[12'h10]), 32'h34);
        chk("mid_mem11", 32'(mem[12'h11]), 32'h5A);
        run_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, flt);
        chk("mid_lhu", rsp_rdata, 32'h00005A34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
